rtype_exec_pipe: RTL and testbench

- Parametrised two-stage MIPS R-type execution unit: register file, decode/operand-read stage and ALU/writeback stage.
- Full EX->ID forwarding; accepts one instruction per cycle, never stalls.
- Adds a host register-load port, an operand/result valid handshake, signed overflow detection and illegal-instruction flagging.
- Sits between the instruction source (bench or fetch unit) and downstream result consumers.

---
 rtl/rtype_pkg.sv | 63 ++++++
 rtl/rtype_alu.sv | 48 ++++
 rtl/rtype_exec_pipe.sv | 137 +++++++++++++
 tb/tb_rtype_exec_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtype_pkg.sv
// rtype_exec_pipe shared types: funct codes, ALU ops, decode helper
// and the ID->EX pipeline bundle.
package rtype_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_ADDU,
        ALU_SUB,
        ALU_SUBU,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    legal;
    } dec_t;

    typedef struct packed {
        logic       valid;
        logic       legal;
        logic [4:0] rd;
        alu_op_e    op;
    } id_ex_t;

    function automatic dec_t decode_funct(input logic [5:0] f);
        dec_t d;
        d.op    = ALU_ADDU;
        d.legal = 1'b1;
        unique case (1'b1)
            (f == FN_ADD):  d.op = ALU_ADD;
            (f == FN_ADDU): d.op = ALU_ADDU;
            (f == FN_SUB):  d.op = ALU_SUB;
            (f == FN_SUBU): d.op = ALU_SUBU;
            (f == FN_AND):  d.op = ALU_AND;
            (f == FN_OR):   d.op = ALU_OR;
            (f == FN_XOR):  d.op = ALU_XOR;
            (f == FN_NOR):  d.op = ALU_NOR;
            (f == FN_SLT):  d.op = ALU_SLT;
            (f == FN_SLTU): d.op = ALU_SLTU;
            default:        d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rtype_alu.sv
// rtype_exec_pipe ALU: combinational R-type datapath
// with signed overflow detect on add/sub.
module rtype_alu
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] y,
    output logic              ovf
);

    localparam int M = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // result select and overflow flag
    always_comb begin
        y   = '0;
        ovf = 1'b0;
        unique case (op)
            ALU_ADD: begin
                y   = sum;
                ovf = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            ALU_SUB: begin
                y   = diff;
                ovf = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            ALU_ADDU: y = sum;
            ALU_SUBU: y = diff;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {{M{1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: y = {{M{1'b0}}, a < b};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/rtype_exec_pipe.sv
// rtype_exec_pipe: two-stage R-type execute with EX->ID forwarding.
// Optional RTYPE_EXEC_DBG_PORT_EN adds dbg_addr/dbg_data RF peek.
module rtype_exec_pipe
    import rtype_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int REG_N  = 32,
    localparam int AW     = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
`ifdef RTYPE_EXEC_DBG_PORT_EN
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
`endif
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              op_valid,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic [AW-1:0]     wb_addr,
    output logic              ovf,
    output logic              illegal
);

    logic [DATA_W-1:0] rf [REG_N];

    logic [4:0]        rs_f;
    logic [4:0]        rt_f;
    logic [4:0]        rd_f;
    logic [AW-1:0]     rs_i;
    logic [AW-1:0]     rt_i;
    dec_t              dec;
    logic              idx_ok;
    logic              id_legal;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] alu_y;
    logic              alu_ovf;
    logic              wb_en;
    id_ex_t            ex_q;
    logic              unused_bits;

    assign rs_f = instr[25:21];
    assign rt_f = instr[20:16];
    assign rd_f = instr[15:11];
    assign rs_i = rs_f[AW-1:0];
    assign rt_i = rt_f[AW-1:0];
    assign dec  = decode_funct(instr[5:0]);

    assign unused_bits = ^{instr[10:6], ex_q.rd};

    if (REG_N < 32) begin : g_idx_chk
        assign idx_ok = (rs_f < 5'(REG_N))
                      & (rt_f < 5'(REG_N))
                      & (rd_f < 5'(REG_N));
    end else begin : g_idx_full
        assign idx_ok = 1'b1;
    end

    assign id_legal = (instr[31:26] == OP_RTYPE)
                    & dec.legal & idx_ok;

    rtype_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a  (A),
        .b  (B),
        .op (ex_q.op),
        .y  (alu_y),
        .ovf(alu_ovf)
    );

    // an EX instruction that will write back is also the forward source
    assign wb_en = ex_q.valid & ex_q.legal & ~alu_ovf
                 & (ex_q.rd != 5'd0);

    assign op_valid = ex_q.valid;

    // operand read; r0 is hard zero, EX result overrides the RF
    always_comb begin
        rs_val = (rs_i == '0) ? '0 : rf[rs_i];
        rt_val = (rt_i == '0) ? '0 : rf[rt_i];
        if (wb_en && (rs_f == ex_q.rd)) rs_val = alu_y;
        if (wb_en && (rt_f == ex_q.rd)) rt_val = alu_y;
    end

`ifdef RTYPE_EXEC_DBG_PORT_EN
    assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];
`endif

    // register file: host load first so a same-edge writeback wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) rf[i] <= '0;
        end else begin
            if (ld_en && (ld_addr != '0)) rf[ld_addr] <= ld_data;
            if (wb_en) rf[ex_q.rd[AW-1:0]] <= alu_y;
        end
    end

    // ID->EX operand latch and EX->result register
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            A            <= '0;
            B            <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            wb_addr      <= '0;
            ovf          <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            ex_q.valid <= instr_valid;
            if (instr_valid) begin
                ex_q.legal <= id_legal;
                ex_q.rd    <= rd_f;
                ex_q.op    <= dec.op;
                A          <= rs_val;
                B          <= rt_val;
            end
            result_valid <= ex_q.valid;
            ovf          <= ex_q.valid & ex_q.legal & alu_ovf;
            illegal      <= ex_q.valid & ~ex_q.legal;
            if (ex_q.valid) begin
                result  <= alu_y;
                wb_addr <= ex_q.rd[AW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_rtype_exec_pipe.sv
// Scoreboard bench for rtype_exec_pipe: sequential ISA model,
// expected A/B and results queued at issue, checked by a monitor.
module tb_rtype_exec_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] A, B, result;
    logic        op_valid, result_valid, ovf, illegal;
    logic [4:0]  wb_addr;
`ifdef RTYPE_EXEC_DBG_PORT_EN
    logic [31:0] dbg_data;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } ab_t;

    typedef struct {
        logic [31:0] y;
        logic [4:0]  rd;
        logic        ov;
        logic        ill;
    } res_t;

    ab_t         abq[$];
    res_t        rq[$];
    logic [31:0] mrf [32];
    int          last_wr = 0;

    rtype_exec_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
`ifdef RTYPE_EXEC_DBG_PORT_EN
        .dbg_addr    (5'd0),
        .dbg_data    (dbg_data),
`endif
        .A           (A),
        .B           (B),
        .op_valid    (op_valid),
        .result      (result),
        .result_valid(result_valid),
        .wb_addr     (wb_addr),
        .ovf         (ovf),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] d,
                                        input logic [4:0] s,
                                        input logic [4:0] t,
                                        input logic [5:0] fn);
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    // architectural meaning of one instruction
    function automatic void ref_alu(input logic [31:0] ins,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] y,
                                    output logic ov,
                                    output logic ok);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        y  = '0;
        ov = 1'b0;
        ok = (ins[31:26] == 6'h00);
        case (ins[5:0])
            6'h20: begin
                s  = sa + sb;
                y  = 32'(s);
                ov = (s != longint'($signed(y)));
            end
            6'h22: begin
                s  = sa - sb;
                y  = 32'(s);
                ov = (s != longint'($signed(y)));
            end
            6'h21: y = a + b;
            6'h23: y = a - b;
            6'h24: y = a & b;
            6'h25: y = a | b;
            6'h26: y = a ^ b;
            6'h27: y = ~(a | b);
            6'h2A: y = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: y = (a < b) ? 32'd1 : 32'd0;
            default: ok = 1'b0;
        endcase
    endfunction

    // one clock edge: drive inputs and advance the sequential model
    task automatic step(input logic r, input logic iv,
                        input logic [31:0] ins, input logic le,
                        input logic [4:0] la, input logic [31:0] ld);
        ab_t         e;
        res_t        x;
        logic [31:0] a, b, y;
        logic        ov, ok;
        int          wr;
        @(negedge clk);
        #1;
        rst = r; instr_valid = iv; instr = ins;
        ld_en = le; ld_addr = la; ld_data = ld;
        if (r) begin
            foreach (mrf[i]) mrf[i] = '0;
            abq.delete();
            rq.delete();
            last_wr = 0;
            return;
        end
        wr = 0;
        y  = '0;
        if (iv) begin
            a = mrf[ins[25:21]];
            b = mrf[ins[20:16]];
            ref_alu(ins, a, b, y, ov, ok);
            e.a = a; e.b = b;
            abq.push_back(e);
            x.y = y; x.rd = ins[15:11];
            x.ov = ok & ov; x.ill = ~ok;
            rq.push_back(x);
            if (ok && !ov && ins[15:11] != 5'd0) wr = int'(ins[15:11]);
        end
        if (le && la != 5'd0 && int'(la) != last_wr) mrf[la] = ld;
        if (wr != 0) mrf[wr] = y;
        last_wr = wr;
    endtask

    task automatic ld(input logic [4:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, 32'h0, 1'b1, a, d);
    endtask

    task automatic ex(input logic [31:0] ins);
        step(1'b0, 1'b1, ins, 1'b0, 5'd0, 32'h0);
    endtask

    // first cycle after a reset edge: everything must read zero
    task automatic post_reset_check();
        @(negedge clk);
        #1;
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_A", A, 32'd0);
        chk("rst_B", B, 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0; instr_valid = 1'b0; ld_en = 1'b0;
        last_wr = 0;
    endtask

    // monitor: pop expectations whenever the DUT presents data
    always @(negedge clk) begin
        ab_t  e;
        res_t x;
        if (op_valid === 1'b1) begin
            if (abq.size() == 0) begin
                chk("op_valid_spurious", 32'd1, 32'd0);
            end else begin
                e = abq.pop_front();
                chk("A", A, e.a);
                chk("B", B, e.b);
            end
        end
        if (result_valid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("result_valid_spurious", 32'd1, 32'd0);
            end else begin
                x = rq.pop_front();
                if (!x.ill) chk("result", result, x.y);
                chk("wb_addr", 32'(wb_addr), 32'(x.rd));
                chk("ovf", 32'(ovf), 32'(x.ov));
                chk("illegal", 32'(illegal), 32'(x.ill));
            end
        end
    end

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rdata();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] fn_tab [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    initial begin
        logic [31:0] ins;
        foreach (mrf[i]) mrf[i] = '0;
        post_reset_check();

        ld(5'd13, 32'd5); ld(5'd11, 32'd3);
        ld(5'd14, 32'd9); ld(5'd9, 32'd4);
        ex(32'h01AB8020);
        ex(32'h01C98822);
        ex(32'h0217A02A);

        ld(5'd1, 32'd1);
        ex(enc(5'd2, 5'd1, 5'd1, 6'h20));
        ex(enc(5'd3, 5'd2, 5'd2, 6'h20));

        step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        post_reset_check();
        ld(5'd1, 32'h7FFF_FFFF); ld(5'd2, 32'd1);
        ex(enc(5'd3, 5'd1, 5'd2, 6'h20));
        ex(enc(5'd4, 5'd3, 5'd0, 6'h25));
        ex(enc(5'd3, 5'd1, 5'd2, 6'h21));
        ex(enc(5'd5, 5'd3, 5'd0, 6'h25));

        ex(32'h8C23_0004);
        ex(enc(5'd0, 5'd1, 5'd1, 6'h20));
        ex(enc(5'd6, 5'd0, 5'd0, 6'h25));

        ld(5'd1, 32'h55);
        ex(enc(5'd5, 5'd1, 5'd0, 6'h25));
        step(1'b0, 1'b0, 32'h0, 1'b1, 5'd5, 32'hAA);
        ex(enc(5'd7, 5'd5, 5'd0, 6'h25));

        ex(enc(5'd8, 5'd5, 5'd5, 6'h21));
        step(1'b1, 1'b1, enc(5'd9, 5'd5, 5'd5, 6'h21),
             1'b1, 5'd9, 32'h123);
        post_reset_check();
        for (int i = 0; i < 32; i++)
            ex(enc(5'd0, 5'(i), 5'(31 - i), 6'h25));

        ld(5'd1, 32'hFFFF_FFFF); ld(5'd2, 32'd1);
        ex(enc(5'd3, 5'd1, 5'd2, 6'h2A));
        ex(enc(5'd4, 5'd1, 5'd2, 6'h2B));
        ex(enc(5'd4, 5'd0, 5'd0, 6'h27));

        for (int n = 0; n < 800; n++) begin
            ins = enc(rreg(), rreg(), rreg(),
                      fn_tab[$urandom_range(0, 9)]);
            if ($urandom_range(0, 15) == 0) ins[5:0] = 6'($urandom);
            if ($urandom_range(0, 19) == 0)
                ins[31:26] = 6'($urandom_range(1, 63));
            ins[10:6] = 5'($urandom);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0, ins,
                 $urandom_range(0, 2) == 0, rreg(), rdata());
        end

        for (int n = 0; n < 4; n++)
            step(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("drain_pending", 32'(abq.size() + rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
